// File: rtl/imag_send.sv
// imag_send: replays one stored 8-bit frame from a RAM read port as a start/work/data stream; om_work trails ram_rd_en by RAM_LAT, no backpressure.
// Define IMAG_SEND_PATTERN_EN to replace RAM data with an (x + y) mod 256 test pattern.
module imag_send #(
    parameter int IMG_W   = 640,
    parameter int IMG_H   = 480,
    parameter int ADDR_W  = 19,
    parameter int RAM_LAT = 1,
    parameter int H_GAP   = 2,
    parameter int F_GAP   = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              im_trig,
    output logic              busy,
    output logic              frame_done,
    output logic              ram_rd_en,
    output logic [ADDR_W-1:0] ram_addr,
    input  logic [7:0]        ram_dout,
    output logic              om_start,
    output logic              om_work,
    output logic [7:0]        om_data
);
    localparam int XW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int YW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam int CW = $clog2(F_GAP + RAM_LAT + H_GAP + 1);

    typedef enum logic [2:0] {IDLE, PRE, LINE, HGAP, POST, DONE} state_t;

    state_t              state, state_nxt;
    logic [XW-1:0]       x;
    logic [YW-1:0]       y;
    logic [CW-1:0]       cnt;
    logic [RAM_LAT-1:0]  work_sr;
    logic [7:0]          data_hold;
    logic [7:0]          pix_src;
    logic                x_last, y_last;
    logic                pattern;

    assign x_last = (x == XW'(IMG_W - 1));
    assign y_last = (y == YW'(IMG_H - 1));

    always_comb begin
        state_nxt  = state;
        busy       = 1'b0;
        om_start   = 1'b0;
        frame_done = 1'b0;
        ram_rd_en  = 1'b0;
        unique case (state)
            IDLE: if (im_trig) state_nxt = PRE;
            PRE:  if (cnt == CW'(F_GAP - 1)) state_nxt = LINE;
            LINE: if (x_last) state_nxt = y_last ? POST : HGAP;
            HGAP: if (cnt == CW'(H_GAP - 1)) state_nxt = LINE;
            POST: if (cnt == CW'(F_GAP + RAM_LAT - 1)) state_nxt = DONE;
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (state != IDLE && state != DONE) begin
            busy     = 1'b1;
            om_start = 1'b1;
        end
        frame_done = (state == DONE);
        ram_rd_en  = (state == LINE) && !pattern;
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            x        <= '0;
            y        <= '0;
            cnt      <= '0;
            ram_addr <= '0;
        end else begin
            if (state_nxt != state || state == IDLE) cnt <= '0;
            else                                     cnt <= cnt + 1'b1;
            case (state)
                IDLE: if (im_trig) begin
                    x        <= '0;
                    y        <= '0;
                    ram_addr <= '0;
                end
                LINE: begin
                    ram_addr <= ram_addr + 1'b1;
                    x        <= x_last ? '0 : x + 1'b1;
                end
                HGAP: if (state_nxt == LINE) y <= y + 1'b1;
                default: ;
            endcase
        end
    end

    // The read strobe is delayed to line up with the returning RAM word.
    always_ff @(posedge clk) begin
        if (rst) begin
            work_sr   <= '0;
            data_hold <= '0;
        end else begin
            work_sr[0] <= (state == LINE);
            for (int i = 1; i < RAM_LAT; i++) work_sr[i] <= work_sr[i-1];
            if (om_work) data_hold <= pix_src;
        end
    end

`ifdef IMAG_SEND_PATTERN_EN
    logic [7:0] pat_sr [RAM_LAT];
    logic       unused_dout;

    assign pattern     = 1'b1;
    assign unused_dout = ^ram_dout;
    assign pix_src     = pat_sr[RAM_LAT-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < RAM_LAT; i++) pat_sr[i] <= '0;
        end else begin
            pat_sr[0] <= 8'(x) + 8'(y);
            for (int i = 1; i < RAM_LAT; i++) pat_sr[i] <= pat_sr[i-1];
        end
    end
`else
    assign pattern = 1'b0;
    assign pix_src = ram_dout;
`endif

    assign om_work = work_sr[RAM_LAT-1];
    // Live word on work cycles, last word otherwise.
    assign om_data = om_work ? pix_src : data_hold;

endmodule
